// File: rtl/cic_decimator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cic_decimator: keeps the last of every rate_act valid samples, strobes it |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cic_decimator #(
  parameter int BITS = 10,
  parameter int RMAX = 16,
  parameter int R    = 4,
  parameter int CW   = $clog2(RMAX + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] stream_in,
  input  logic            valid,
  input  logic [CW-1:0]   rate,
  input  logic            sync,
  output logic [BITS-1:0] stream_out,
  output logic            ready,
  output logic [CW-1:0]   phase
);

  localparam logic [CW-1:0] RATE_RST = CW'((R < 1) ? 1 : ((R > RMAX) ? RMAX : R));

  function automatic logic [CW-1:0] clamp(input logic [CW-1:0] r);
    if (r == '0)
      return CW'(1);
    else if (int'(r) > RMAX)
      return CW'(RMAX);
    else
      return r;
  endfunction

  logic [CW-1:0] count;
  logic [CW-1:0] rate_act;
  logic [CW-1:0] rate_new;
  logic          boundary;

  assign rate_new = clamp(rate);
  assign boundary = (count == rate_act - CW'(1));
  assign phase    = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      rate_act   <= RATE_RST;
      stream_out <= '0;
      ready      <= 1'b0;
    end else if (sync) begin
      // A sample arriving with sync opens the new block, judged at the new rate
      rate_act <= rate_new;
      ready    <= 1'b0;
      count    <= '0;
      if (valid) begin
        if (rate_new == CW'(1)) begin
          stream_out <= stream_in;
          ready      <= 1'b1;
        end else begin
          count <= CW'(1);
        end
      end
    end else if (valid) begin
      if (boundary) begin
        stream_out <= stream_in;
        ready      <= 1'b1;
        count      <= '0;
        rate_act   <= rate_new;
      end else begin
        count <= count + CW'(1);
        ready <= 1'b0;
      end
    end else begin
      ready <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cic_decimator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cic_decimator: directed + random stimulus against a block-queue model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_cic_decimator;

  localparam int BITS = 10;
  localparam int RMAX = 16;
  localparam int R    = 4;
  localparam int CW   = $clog2(RMAX + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic [BITS-1:0] stream_in;
  logic            valid;
  logic [CW-1:0]   rate;
  logic            sync;
  logic [BITS-1:0] stream_out;
  logic            ready;
  logic [CW-1:0]   phase;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  cic_decimator #(.BITS(BITS), .RMAX(RMAX), .R(R), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .stream_in (stream_in),
    .valid     (valid),
    .rate      (rate),
    .sync      (sync),
    .stream_out(stream_out),
    .ready     (ready),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  // Reference: a block is the list of samples accepted since the last emit or realign
  int              m_rate;
  int              blk[$];
  logic [BITS-1:0] m_out;
  logic            m_ready;

  function automatic int ref_clamp(input int r);
    return (r < 1) ? 1 : ((r > RMAX) ? RMAX : r);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      blk.delete();
      m_rate  = ref_clamp(R);
      m_out   = '0;
      m_ready = 1'b0;
    end else begin
      m_ready = 1'b0;
      if (sync) begin
        blk.delete();
        m_rate = ref_clamp(int'(rate));
      end
      if (valid) begin
        blk.push_back(int'(stream_in));
        if (blk.size() == m_rate) begin
          m_out   = stream_in;
          m_ready = 1'b1;
          blk.delete();
          m_rate  = ref_clamp(int'(rate));
        end
      end
    end
  end

  task automatic check_val(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check_val("cmp_stream_out", int'(stream_out), int'(m_out));
      check_val("cmp_ready", int'(ready), int'(m_ready));
      check_val("cmp_phase", int'(phase), blk.size());
    end
  end

  int emitted[$];
  always @(negedge clk) begin
    if (!rst && ready) emitted.push_back(int'(stream_out));
  end

  task automatic drive(input logic v, input int d, input logic s, input int r);
    valid     = v;
    stream_in = BITS'(d);
    sync      = s;
    rate      = CW'(r);
    @(negedge clk);
  endtask

  task automatic check_emit(input string nm, input int n, input int e0,
                            input int e1 = 0, input int e2 = 0, input int e3 = 0);
    int ev[4];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    check_val({nm, "_count"}, emitted.size(), n);
    for (int i = 0; i < n; i++) check_val(nm, emitted[i], ev[i]);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; sync = 1'b0; stream_in = '0; rate = CW'(R);
    repeat (3) @(negedge clk);
    check_val("reset_stream_out", int'(stream_out), 0);
    check_val("reset_ready", int'(ready), 0);
    check_val("reset_phase", int'(phase), 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Continuous run at the reset rate
    emitted.delete();
    for (int d = 1; d <= 12; d++) begin
      drive(1'b1, d, 1'b0, 4);
      if (d == 3) check_val("cont_phase3", int'(phase), 3);
      if (d == 4) begin
        check_val("cont_phase_wrap", int'(phase), 0);
        check_val("cont_ready4", int'(ready), 1);
      end
    end
    drive(1'b0, 0, 1'b0, 4);
    check_emit("cont_out", 3, 4, 8, 12);

    // Gapped input at rate 3
    drive(1'b0, 0, 1'b1, 3);
    emitted.delete();
    for (int d = 10; d <= 15; d++) begin
      drive(1'b1, d, 1'b0, 3);
      drive(1'b0, 0, 1'b0, 3);
      if (d == 13) check_val("gap_held", int'(stream_out), 12);
    end
    check_emit("gap_out", 2, 12, 15);

    // Rate change mid-block applies from the next block
    drive(1'b0, 0, 1'b1, 4);
    emitted.delete();
    for (int d = 1; d <= 10; d++) drive(1'b1, d, 1'b0, (d <= 2) ? 4 : 2);
    drive(1'b0, 0, 1'b0, 2);
    check_emit("rchg_out", 4, 4, 6, 8, 10);

    // Rate 0 clamps to pass-through
    drive(1'b0, 0, 1'b1, 0);
    emitted.delete();
    drive(1'b1, 7, 1'b0, 0);
    check_val("pass_ready7", int'(ready), 1);
    drive(1'b1, 8, 1'b0, 0);
    check_val("pass_ready8", int'(ready), 1);
    drive(1'b1, 9, 1'b0, 0);
    check_val("pass_ready9", int'(ready), 1);
    drive(1'b0, 0, 1'b0, 0);
    check_emit("pass_out", 3, 7, 8, 9);

    // Rate 31 clamps to RMAX
    drive(1'b0, 0, 1'b1, 31);
    emitted.delete();
    for (int d = 1; d <= 16; d++) begin
      drive(1'b1, d, 1'b0, 31);
      if (d == 15) begin
        check_val("clamp_phase15", int'(phase), 15);
        check_val("clamp_noready", int'(ready), 0);
      end
    end
    drive(1'b0, 0, 1'b0, 31);
    check_emit("clamp_out", 1, 16);

    // Sync together with valid opens a new block with that sample
    drive(1'b0, 0, 1'b1, 4);
    drive(1'b1, 40, 1'b0, 4);
    drive(1'b1, 41, 1'b0, 4);
    emitted.delete();
    drive(1'b1, 50, 1'b1, 4);
    check_val("syncv_phase", int'(phase), 1);
    check_val("syncv_ready", int'(ready), 0);
    for (int d = 51; d <= 53; d++) drive(1'b1, d, 1'b0, 4);
    drive(1'b0, 0, 1'b0, 4);
    check_emit("syncv_out", 1, 53);

    // Asynchronous reset between edges while phase is 3
    drive(1'b0, 0, 1'b1, 4);
    for (int d = 1; d <= 3; d++) drive(1'b1, d, 1'b0, 4);
    check_val("rst_pre_phase", int'(phase), 3);
    valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_val("rst_async_out", int'(stream_out), 0);
    check_val("rst_async_ready", int'(ready), 0);
    check_val("rst_async_phase", int'(phase), 0);
    #1 rst = 1'b0;
    @(negedge clk);
    emitted.delete();
    for (int d = 60; d <= 63; d++) drive(1'b1, d, 1'b0, 4);
    drive(1'b0, 0, 1'b0, 4);
    check_emit("rst_after_out", 1, 63);

    // Randomised traffic against the model
    begin
      int r_cur;
      r_cur = 4;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 19) == 0) r_cur = $urandom_range(0, 31);
        drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, int'($urandom_range(0, 1023)),
              ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, r_cur);
      end
    end
    drive(1'b0, 0, 1'b0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cic_decimator.md
# cic_decimator

Rate-change stage of the CIC decimation chain. Sits between the integrator cascade and the comb cascade. It keeps one of every `rate` valid input samples and presents it to the comb with a single-cycle strobe. The decimation rate is programmable at run time up to `RMAX`, and a rate change takes effect only on a block boundary.

## Interface
- `BITS`, default 10: sample width, input and output.
- `RMAX`, default 16: largest supported decimation rate.
- `R`, default 4: decimation rate loaded at reset.
- `CW`, default `$clog2(RMAX+1)`: width of the rate port and the phase counter.
- `clk`  in  1: clock. All state changes on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `stream_in`  in  BITS: integrator output sample.
- `valid`  in  1: `stream_in` is valid this cycle. One sample is accepted per high cycle.
- `rate`  in  CW: requested decimation rate. Sampled only at the load points listed under Operation.
- `sync`  in  1: synchronous realign. Restarts block phase and loads `rate`.
- `stream_out`  out  BITS: decimated sample, held between strobes. Drives comb `stream_in`.
- `ready`  out  1: one-cycle strobe, `stream_out` is new. Drives comb `valid`.
- `phase`  out  CW: current position within the block, 0..rate_act-1 (debug).

## Operation
- Internal state:
  - `count` (CW bits), the phase counter; `phase` = `count`.
  - `rate_act` (CW bits), the active rate.
  - `stream_out` and `ready` registers.
- Rate clamp, applied whenever a rate is loaded: 0 → 1; values > RMAX → RMAX; otherwise unchanged. Rate 1 is pass-through.
- Reset (`rst`=1, asynchronous):
  - `count`=0, `rate_act`=clamp(R).
  - `stream_out`=0, `ready`=0, `phase`=0.
- Priority each cycle: `sync` first, then `valid`.
- `sync`=1, `valid`=0:
  - `count`←0, `rate_act`←clamp(`rate`), `ready`←0.
  - `stream_out` is held.
- `sync`=1, `valid`=1: the present sample becomes sample 0 of a new block, judged against the new rate rn = clamp(`rate`).
  - `rate_act`←rn.
  - If rn=1: emit the sample (`stream_out`←`stream_in`, `ready`←1), `count`←0.
  - Otherwise: `count`←1, `ready`←0.
- `sync`=0, `valid`=1, `count`==`rate_act`-1 (block boundary):
  - `stream_out`←`stream_in`, `ready`←1, `count`←0.
  - `rate_act`←clamp(`rate`). A new rate applies from the next block only.
- `sync`=0, `valid`=1, any other `count`:
  - `count`←`count`+1, `ready`←0.
- `sync`=0, `valid`=0:
  - `ready`←0. `count`, `rate_act` and `stream_out` are held.
  - Gaps in `valid` do not disturb phase.
- The emitted sample is always the last of each block of `rate_act` accepted samples.
- Width rules:
  - No arithmetic is done on data. `stream_out` is a bit-exact copy of `stream_in`.
  - `count` never exceeds `rate_act`-1, so no wrap beyond the active rate is possible.

## Timing
- Latency: 1 cycle. The strobe appears on the cycle after the accepted boundary sample.
- `ready` is high for exactly one cycle per emitted sample.
- Strobe rate:
  - At `rate`=1 with continuous `valid`, `ready` may be high on consecutive cycles.
  - Otherwise, with continuous `valid`, strobes are spaced exactly `rate_act` cycles apart.
- Downstream comb needs no back-pressure path. The comb accepts a sample on every `ready` cycle.
- Reset mid-block: outputs drop asynchronously. The first post-reset block begins with the first `valid` after `rst` falls.
- If `rate` changes while no boundary occurs, it has no effect until the next boundary or `sync`.

## Test plan
- Continuous run:
  - Stimulus: R=4, `valid` continuous, `stream_in`=1,2,...,12.
  - Required: `ready` pulses one cycle after inputs 4, 8 and 12, with `stream_out`=4, 8, 12. `phase` cycles 0,1,2,3.
- Gapped input:
  - Stimulus: R=3, `valid` high on alternate cycles, data 10..15.
  - Required: outputs 12 and 15, each one cycle after its accepted sample. `stream_out` held between strobes.
- Rate change mid-block:
  - Stimulus: R=4; set `rate`=2 after input 2; data 1..10 continuous.
  - Required: first output 4, then outputs 6, 8, 10.
- Clamp and pass-through:
  - Stimulus: `rate`=0 loaded via `sync`, data 7,8,9.
  - Required: outputs 7, 8, 9 on consecutive cycles.
  - Stimulus: `rate`=31 with RMAX=16.
  - Required: `rate_act`=16.
- Sync with valid:
  - Stimulus: R=4, `count`=2, assert `sync`+`valid` with data 50, `rate`=4.
  - Required: `phase`=1 next cycle, no strobe. Next output is the 4th sample counting 50.
- Reset mid-operation:
  - Stimulus: assert `rst` asynchronously between clock edges while `count`=3.
  - Required: `stream_out`=0, `ready`=0, `phase`=0 immediately. After release, the first output comes on the 4th valid.
